cim_param_loader: RTL and testbench
===================================

# cim_param_loader

Streams parameter and input words from an external valid/ready source into the centralized CIM's on-chip memory. The CIM reads this memory during inference; this block is the writer at the other end of that memory port. Per load it:
- writes a programmed number of words to consecutive addresses from a base address;
- keeps a running checksum of the words written;
- signals completion with a one-cycle done pulse.

## Interface

Parameters:
- DATA_W, 16, width of one memory word and of the checksum.
- ADDR_W, 9, memory address width; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  ADDR_W  first write address; sampled with an accepted start.
- num_words  input  ADDR_W+1  words to write, 0..2^ADDR_W; sampled with an accepted start.
- in_data  input  DATA_W  stream data.
- in_valid  input  1  stream data valid.
- in_ready  output  1  loader can accept a word this cycle.
- mem_busy  input  1  CIM currently owns the memory port; loader must not write.
- mem_wr_en  output  1  write strobe to CIM memory.
- mem_addr  output  ADDR_W  write address.
- mem_wr_data  output  DATA_W  write data.
- busy  output  1  high while state is LOAD.
- done  output  1  one-cycle pulse at end of load.
- checksum  output  DATA_W  sum modulo 2^DATA_W of all words accepted in the current or last load.
- start_err  output  1  sticky; set when start is asserted while busy; cleared by the next accepted start.

## Operation

States:
- IDLE: in_ready = 0.
  - start = 1 → latch base_addr and num_words, clear word counter and checksum, clear start_err.
  - If num_words = 0: stay in IDLE and pulse done the next cycle. No writes occur.
  - Otherwise: go to LOAD.
- LOAD:
  - in_ready = !mem_busy.
  - Transfer occurs when in_valid && in_ready.
  - On each transfer: register the word into mem_wr_data, set mem_addr = (base + count) mod 2^ADDR_W, set mem_wr_en = 1 for exactly the next cycle, increment count, add the word to checksum (carry discarded).
  - When the transfer is word num_words (count = num_words−1 before increment) → IDLE.
- mem_busy may rise at any time. Its only effect is to deassert in_ready combinationally. A write already registered (mem_wr_en high) always completes, because the CIM arbiter grants one-cycle slack after raising mem_busy.
- start while in LOAD: ignored, sets start_err. The load continues unaffected.
- The word counter is ADDR_W+1 bits, so num_words = 2^ADDR_W writes every address exactly once and mem_addr wraps back to base_addr's predecessor.
- Reset (any time, including mid-load): state IDLE, count 0, latched base and length 0.
  - Reset outputs: in_ready 0, mem_wr_en 0, mem_addr 0, mem_wr_data 0, busy 0, done 0, checksum 0, start_err 0.
  - A write pending in the pipeline is dropped.

## Timing

- start accepted at cycle t → busy = 1 and in_ready = !mem_busy from cycle t+1.
- Transfer at cycle k → mem_wr_en, mem_addr and mem_wr_data valid in cycle k+1. checksum includes the word from cycle k+1.
- Last transfer at cycle k → in cycle k+1:
  - state IDLE, busy = 0, in_ready = 0;
  - the last mem_wr_en is high;
  - done = 1;
  - checksum is final.
- A new start may be asserted in cycle k+1 and is accepted.
- num_words = 0 with start at t → done = 1 at t+1, busy stays 0, no mem_wr_en.
- Throughput: one word per cycle when in_valid = 1 and mem_busy = 0.
- Write count from accepted start to done equals num_words exactly. Gaps caused by in_valid low or mem_busy high cause no duplicates and no skips.
- done is never high for two consecutive cycles. checksum holds its value until the next accepted start.

## Test plan

- Basic load: base_addr 0x010, num_words 4, words 0x0001, 0x0002, 0x0003, 0x0004 back-to-back with in_valid held 1.
  - Required: writes to 0x010..0x013 in 4 consecutive cycles, done with the 4th write, checksum 0x000A.
- Wrap and overflow: base_addr 0x1FE, num_words 3, words 0xFFFF, 0x0002, 0x0001.
  - Required: addresses 0x1FE, 0x1FF, 0x000; checksum 0x0002.
- Backpressure: num_words 3; mem_busy high for 2 cycles after the first transfer, and in_valid toggling.
  - Required: in_ready low exactly while mem_busy is high.
  - Required: exactly 3 writes with in-order data, and one done pulse.
- Zero length and start error:
  - start with num_words 0 → done at t+1 and no mem_wr_en.
  - start asserted mid-load → start_err = 1 and the load completes normally.
  - Next accepted start clears start_err.
- Reset mid-load: assert rst_n low after 2 of 5 words.
  - Required: all outputs 0 immediately (asynchronous).
  - Required: a following load of 2 words to base 0x040 writes only 0x040 and 0x041.
- Full memory: num_words 512, base_addr 0x000, random data.
  - Required: all 512 addresses written once and done after 512 writes.
  - Required: checksum matches the model sum modulo 2^16.

Source files
------------

// File: rtl/cim_param_loader.sv
// cim_param_loader: streams words from a valid/ready source into CIM memory.
// Each load writes num_words words to consecutive (wrapping) addresses from
// base_addr, keeps a modulo-2^DATA_W checksum, and pulses done at the end.
module cim_param_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_busy,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic              start_err
);

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_ZERO = '0;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt_q;
  logic              done_q;
  logic              start_err_q;

  logic              xfer_p0;
  logic              last_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;
  logic [DATA_W-1:0] csum_p1;

  // Checksum accumulation: carry out of the top bit is intentionally discarded.
  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  // Stage p0: handshake. mem_busy only gates readiness; it never cancels a
  // write that is already registered, since the arbiter gives one cycle slack.
  assign in_ready = (state == S_LOAD) && !mem_busy;
  assign xfer_p0  = in_valid && in_ready;
  assign last_p0  = xfer_p0 && ((cnt_q + CNT_ONE) == len_q);

  // Load sequencing: latch the request, count accepted words, flag misuse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            len_q       <= num_words;
            cnt_q       <= '0;
            start_err_q <= 1'b0;
            if (num_words == CNT_ZERO) begin
              done_q <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (start) begin
            start_err_q <= 1'b1;
          end
          if (xfer_p0) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
          if (last_p0) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: registered write to memory plus the running checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      csum_p1 <= '0;
    end else begin
      vld_p1 <= xfer_p0;
      if (xfer_p0) begin
        addr_p1 <= base_q + cnt_q[ADDR_W-1:0];
        data_p1 <= in_data;
      end
      if ((state == S_IDLE) && start) begin
        csum_p1 <= '0;
      end else if (xfer_p0) begin
        csum_p1 <= wrap_add(csum_p1, in_data);
      end
    end
  end

  assign mem_wr_en   = vld_p1;
  assign mem_addr    = addr_p1;
  assign mem_wr_data = data_p1;
  assign checksum    = csum_p1;
  assign busy        = (state == S_LOAD);
  assign done        = done_q;
  assign start_err   = start_err_q;

endmodule

// File: tb/tb_cim_param_loader.sv
// Testbench for cim_param_loader: randomized loads with a queue scoreboard.
module tb_cim_param_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  base_addr;
  logic [9:0]  num_words;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_busy;
  logic        mem_wr_en;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wr_data;
  logic        busy;
  logic        done;
  logic [15:0] checksum;
  logic        start_err;

  cim_param_loader #(.DATA_W(16), .ADDR_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_busy(mem_busy), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .busy(busy),
    .done(done), .checksum(checksum), .start_err(start_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [15:0] cq[$];
  logic [15:0] wd[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wr_en"}, mem_wr_en, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_checksum"}, checksum, 0);
    check({tag, "_start_err"}, start_err, 0);
  endtask

  // Monitor: pops expected writes and checksums whenever the DUT presents them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wr_en) begin
        check("wr_expected", (wq.size() > 0), 1);
        if (wq.size() > 0) begin
          wr_t e;
          e = wq.pop_front();
          check("wr_addr", mem_addr, e.a);
          check("wr_data", mem_wr_data, e.d);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_double", prev_done, 0);
        check("done_expected", (cq.size() > 0), 1);
        if (cq.size() > 0) check("checksum_at_done", checksum, cq.pop_front());
        check("writes_left_at_done", wq.size(), 0);
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // One load: model expectations are derived purely from base, length and wd.
  task automatic do_load(input logic [8:0] base, input int n, input int vld_pct,
                         input int busy_pct, input int err_at, input int abort_at);
    logic [15:0] sum;
    int          idx;
    int          cyc;
    int          d0;
    logic        xfer;
    sum = '0;
    @(posedge clk); #2;
    start     = 1'b1;
    base_addr = base;
    num_words = 10'(n);
    in_valid  = 1'b0;
    mem_busy  = 1'b0;
    for (int i = 0; i < n; i++) begin
      wq.push_back('{a: 9'((int'(base) + i) % 512), d: wd[i]});
      sum = sum + wd[i];
    end
    cq.push_back(sum);
    d0 = done_cnt;
    @(posedge clk); #2;
    start = 1'b0;
    check("busy_after_start", busy, (n > 0));
    check("start_err_cleared", start_err, 0);
    if (n == 0) check("zero_done_t1", done, 1);
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 20000) begin
      if (abort_at >= 0 && idx == abort_at) begin
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        wq.delete();
        cq.delete();
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        return;
      end
      start     = (idx == err_at);
      base_addr = 9'($urandom);
      num_words = 10'd7;
      in_valid  = ($urandom_range(99) < vld_pct);
      mem_busy  = ($urandom_range(99) < busy_pct);
      in_data   = in_valid ? wd[idx] : 16'($urandom);
      #1;
      check("in_ready_vs_busy", in_ready, !mem_busy);
      xfer = in_valid && in_ready;
      @(posedge clk); #2;
      if (xfer) idx++;
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    mem_busy = 1'b0;
    check("load_complete", idx, n);
    if (vld_pct == 100 && busy_pct == 0) check("full_rate_cycles", cyc, n);
    check("busy_after_last", busy, 0);
    #1 check("in_ready_after_last", in_ready, 0);
    if (err_at >= 0 && err_at < n) check("start_err_set", start_err, 1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("one_done_pulse", done_cnt, d0 + 1);
    check("done_low_after", done, 0);
    check("checksum_hold", checksum, sum);
    check("no_stray_writes", wq.size(), 0);
  endtask

  task automatic fill_random(input int n);
    wd.delete();
    for (int i = 0; i < n; i++) wd.push_back(16'($urandom));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    mem_busy  = 1'b0;
    #1 check_all_zero("reset");
    #20 rst_n = 1'b1;

    wd = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    do_load(9'h010, 4, 100, 0, -1, -1);

    wd = '{16'hFFFF, 16'h0002, 16'h0001};
    do_load(9'h1FE, 3, 100, 0, -1, -1);

    for (int k = 0; k < 6; k++) begin
      fill_random(3 + k);
      do_load(9'($urandom), 3 + k, 60, 40, -1, -1);
    end

    wd.delete();
    do_load(9'h055, 0, 100, 0, -1, -1);

    fill_random(6);
    do_load(9'h100, 6, 80, 20, 2, -1);
    fill_random(2);
    do_load(9'h0A0, 2, 100, 0, -1, -1);

    fill_random(5);
    do_load(9'h020, 5, 100, 0, -1, 2);
    wd = '{16'h1234, 16'h5678};
    do_load(9'h040, 2, 100, 0, -1, -1);

    fill_random(512);
    do_load(9'h000, 512, 100, 0, -1, -1);

    fill_random(40);
    do_load(9'h1F0, 40, 70, 30, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
